multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RISC-V control FSM with memory wait watchdog
// Optional feature macro: ILLEGAL_OP_TRAP_EN (unsupported opcode traps to FAULT instead of no-op)
module multicycle_control_unit #(
    parameter int OPWIDTH    = 7,
    parameter int ALUCWIDTH  = 3,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPWIDTH-1:0]   op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic [ALUCWIDTH-1:0] alu_control,
    output logic                 fault,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    localparam logic [OPWIDTH-1:0] OP_LOAD  = OPWIDTH'(7'b0000011);
    localparam logic [OPWIDTH-1:0] OP_STORE = OPWIDTH'(7'b0100011);
    localparam logic [OPWIDTH-1:0] OP_RTYPE = OPWIDTH'(7'b0110011);
    localparam logic [OPWIDTH-1:0] OP_ITYPE = OPWIDTH'(7'b0010011);
    localparam logic [OPWIDTH-1:0] OP_BEQ   = OPWIDTH'(7'b1100011);
    localparam logic [OPWIDTH-1:0] OP_JAL   = OPWIDTH'(7'b1101111);
    localparam logic [7:0]         WAIT_MAX = 8'(WAIT_LIMIT);

    state_t     state_q;
    state_t     state_n;
    logic [7:0] wait_cnt;
    logic       timeout;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_decode = sub ? 3'b001 : 3'b000;
            3'b010:  alu_decode = 3'b010;
            3'b110:  alu_decode = 3'b011;
            3'b111:  alu_decode = 3'b100;
            default: alu_decode = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            wait_cnt <= 8'd0;
        end else begin
            state_q <= state_n;
            // Saturate so a stalled request can never wrap back below the limit
            if (mem_req && !mem_ready) begin
                if (wait_cnt != 8'hff) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

    assign timeout = (wait_cnt >= WAIT_MAX);

    always_comb begin
        state_n     = state_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        alu_control = '0;

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (op == OP_LOAD || op == OP_STORE) state_n = S_MEMADR;
                else if (op == OP_RTYPE)             state_n = S_EXECR;
                else if (op == OP_ITYPE)             state_n = S_EXECI;
                else if (op == OP_BEQ)               state_n = S_BEQ;
                else if (op == OP_JAL)               state_n = S_JAL;
                else begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_n = S_FAULT;
`else
                    state_n = S_FETCH;
`endif
                end
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_STORE) ? 2'b01 : 2'b00;
                state_n   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_n = S_MEMWB;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_n = S_FETCH;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_n    = S_FETCH;
            end
            S_EXECR: begin
                alu_control = ALUCWIDTH'(alu_decode(funct3, funct7b5));
                state_n     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b   = 2'b01;
                alu_control = ALUCWIDTH'(alu_decode(funct3, 1'b0));
                state_n     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_n   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                imm_src     = 2'b10;
                alu_control = ALUCWIDTH'(3'b001);
                pc_write    = zero;
                state_n     = S_FETCH;
            end
            S_JAL: begin
                imm_src   = 2'b11;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_n   = S_ALUWB;
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_FAULT;
        endcase

        // A memory access stalled past the limit overrides any normal transition
        if (timeout) state_n = S_FAULT;
    end

    assign fault = (state_q == S_FAULT);
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - table-driven check of multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clk, rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       mem_req, mem_write, pc_write, adr_src, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       fault;
    logic [3:0] state;

    multicycle_control_unit #(.OPWIDTH(7), .ALUCWIDTH(3), .WAIT_LIMIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .fault(fault), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, J = 7'b1101111, BAD = 7'b1111111;

    // control bits: {fault, mem_req, mem_write, pc_write, adr_src, ir_write, reg_write}
    localparam logic [6:0] C0 = 7'b0000000, CF0 = 7'b0100000, CF1 = 7'b0101010;
    localparam logic [6:0] CMR = 7'b0100100, CMW = 7'b0110100, CRW = 7'b0000001;
    localparam logic [6:0] CPC = 7'b0001000, CFT = 7'b1000000;

    typedef struct {
        logic       rst_n;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       rdy;
        logic [3:0] st;
        logic [17:0] outs;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic r, input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input logic z, input logic rdy,
                                input logic [3:0] st, input logic [6:0] ctl,
                                input logic [1:0] res, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] imm,
                                input logic [2:0] alu);
        vec_t v;
        v.rst_n = r; v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z; v.rdy = rdy;
        v.st = st; v.outs = {ctl, res, a, b, imm, alu};
        return v;
    endfunction

    function automatic logic [17:0] actual_outs();
        return {fault, mem_req, mem_write, pc_write, adr_src, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control};
    endfunction

    task automatic check_state(input string name, input logic [3:0] exp);
        n_vec++;
        if (state !== exp) begin
            n_bad++;
            $display("FAIL %s: state got %0d expected %0d", name, state, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [17:0] exp);
        n_vec++;
        if (actual_outs() !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %b expected %b", name, actual_outs(), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; op = R; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type sub
        vecs.push_back(mk(1, R, 3'b000, 1, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, R, 3'b000, 1, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, R, 3'b000, 1, 0, 1, 6, C0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, R, 3'b000, 1, 0, 1, 8, CRW, 0, 0, 0, 0, 0));
        // load, one fetch wait, MEMREAD held 4 cycles
        vecs.push_back(mk(1, LD, 3'b000, 0, 0, 0, 0, CF0, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, LD, 3'b000, 0, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, LD, 3'b000, 0, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, LD, 3'b000, 0, 0, 1, 2, C0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(1, LD, 3'b000, 0, 0, 0, 3, CMR, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, LD, 3'b000, 0, 0, 0, 3, CMR, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, LD, 3'b000, 0, 0, 0, 3, CMR, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, LD, 3'b000, 0, 0, 1, 3, CMR, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, LD, 3'b000, 0, 0, 1, 4, CRW, 1, 0, 0, 0, 0));
        // store with one write wait
        vecs.push_back(mk(1, ST, 3'b000, 0, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, ST, 3'b000, 0, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, ST, 3'b000, 0, 0, 1, 2, C0, 0, 2, 1, 1, 0));
        vecs.push_back(mk(1, ST, 3'b000, 0, 0, 0, 5, CMW, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, ST, 3'b000, 0, 0, 1, 5, CMW, 0, 0, 0, 0, 0));
        // beq taken then not taken
        vecs.push_back(mk(1, BR, 3'b000, 0, 1, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, BR, 3'b000, 0, 1, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, BR, 3'b000, 0, 1, 1, 9, CPC, 0, 2, 0, 2, 1));
        vecs.push_back(mk(1, BR, 3'b000, 0, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, BR, 3'b000, 0, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, BR, 3'b000, 0, 0, 1, 9, C0, 0, 2, 0, 2, 1));
        // I-type or (funct7b5 ignored), I-type add with funct7b5 set
        vecs.push_back(mk(1, I, 3'b110, 1, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, I, 3'b110, 1, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, I, 3'b110, 1, 0, 1, 7, C0, 0, 0, 1, 0, 3));
        vecs.push_back(mk(1, I, 3'b110, 1, 0, 1, 8, CRW, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, I, 3'b000, 1, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, I, 3'b000, 1, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, I, 3'b000, 1, 0, 1, 7, C0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, I, 3'b000, 1, 0, 1, 8, CRW, 0, 0, 0, 0, 0));
        // jal
        vecs.push_back(mk(1, J, 3'b000, 0, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, J, 3'b000, 0, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, J, 3'b000, 0, 0, 1, 10, CPC, 0, 1, 2, 3, 0));
        vecs.push_back(mk(1, J, 3'b000, 0, 0, 1, 8, CRW, 0, 0, 0, 0, 0));
        // R-type and / slt / unlisted funct3
        vecs.push_back(mk(1, R, 3'b111, 0, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, R, 3'b111, 0, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, R, 3'b111, 0, 0, 1, 6, C0, 0, 0, 0, 0, 4));
        vecs.push_back(mk(1, R, 3'b111, 0, 0, 1, 8, CRW, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, R, 3'b010, 0, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, R, 3'b010, 0, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, R, 3'b010, 0, 0, 1, 6, C0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, R, 3'b010, 0, 0, 1, 8, CRW, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, R, 3'b001, 1, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, R, 3'b001, 1, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, R, 3'b001, 1, 0, 1, 6, C0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, R, 3'b001, 1, 0, 1, 8, CRW, 0, 0, 0, 0, 0));
        // reset asserted while MEMWRITE is waiting
        vecs.push_back(mk(1, ST, 3'b000, 0, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, ST, 3'b000, 0, 0, 1, 1, C0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, ST, 3'b000, 0, 0, 1, 2, C0, 0, 2, 1, 1, 0));
        vecs.push_back(mk(0, ST, 3'b000, 0, 0, 0, 5, CMW, 0, 0, 0, 0, 0));
        // illegal opcode
        vecs.push_back(mk(1, BAD, 3'b000, 0, 0, 1, 0, CF1, 2, 0, 2, 0, 0));
        vecs.push_back(mk(1, BAD, 3'b000, 0, 0, 1, 1, C0, 0, 1, 1, 0, 0));
`ifdef ILLEGAL_OP_TRAP_EN
        vecs.push_back(mk(1, BAD, 3'b000, 0, 0, 1, 11, CFT, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, BAD, 3'b000, 0, 0, 1, 11, CFT, 0, 0, 0, 0, 0));
`else
        vecs.push_back(mk(1, BAD, 3'b000, 0, 0, 0, 0, CF0, 2, 0, 2, 0, 0));
`endif

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; op = vecs[i].op; funct3 = vecs[i].f3;
            funct7b5 = vecs[i].f7; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            #1;
            check_state($sformatf("vec%0d_state", i), vecs[i].st);
            check_outs($sformatf("vec%0d_outs", i), vecs[i].outs);
            tick();
        end

        // 14 fetch waits then ready: just under the watchdog limit
        op = R; mem_ready = 1'b0;
        do_reset();
        repeat (14) tick();
        mem_ready = 1'b1;
        tick();
        check_state("wait14_no_fault", 4'd1);

        // stuck fetch: 15 counted waits, FAULT on the following edge
        mem_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            #1;
            check_state($sformatf("stall_hold%0d", k), 4'd0);
            tick();
        end
        check_state("stall_fault_state", 4'd11);
        check_outs("stall_fault_outs", {CFT, 11'd0});
        mem_ready = 1'b1;
        tick();
        check_state("fault_absorbing", 4'd11);
        do_reset();
        #1;
        check_outs("fault_cleared_by_reset", {CF1, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0});
        check_state("fault_reset_state", 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
